// File: rtl/mdu_if.sv
// Request/response bundle between the execute-stage controller and the
// iterative multiply/divide sequencer.
interface mdu_if #(
    parameter int WIDTH = 32
);
    // start is a one-cycle request that is taken only while the sequencer is
    // idle or done (busy=0); busy stalls the pipeline; done pulses for one cycle
    // with result valid, and result then holds until the next completion.
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, srca, srcb, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, srca, srcb, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up and early-out cases.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_if.slave       bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_next;
    logic   accept;

    logic [2:0]         op;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   result_q;

    // Operand preparation for the request currently presented on the bus.
    logic             sign_a, sign_b, early;
    logic [WIDTH-1:0] mag_a, mag_b, early_val;

    always_comb begin
        sign_a    = 1'b0;
        sign_b    = 1'b0;
        early_val = '0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                sign_a = bus.srca[WIDTH-1];
                sign_b = bus.srcb[WIDTH-1];
            end
            3'b010: sign_a = bus.srca[WIDTH-1];
            default: ;
        endcase
        mag_a = sign_a ? -bus.srca : bus.srca;
        mag_b = sign_b ? -bus.srcb : bus.srcb;
        early = bus.funct3[2] && ((bus.srcb == '0) ||
                (!bus.funct3[0] && bus.srca == MIN_INT && bus.srcb == '1));
        if (bus.srcb == '0)
            early_val = bus.funct3[1] ? bus.srca : '1;
        else
            early_val = bus.funct3[1] ? '0 : MIN_INT;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = early ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC:    if (cnt == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
    end

    assign bus.busy   = (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign dbg_state  = state;

    // One iteration of each algorithm. acc holds {high, low} for multiply
    // and {remainder, quotient} for divide; opnd is multiplicand or divisor.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_top;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_val;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        // The shifted-out top bit is kept so a partial remainder above 2^WIDTH-1 compares correctly.
        div_top  = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_top >= {1'b0, opnd};
        div_diff = div_top[WIDTH-1:0] - opnd;
        div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        prod     = neg_q ? -acc : acc;
        quo      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (op[2])
            fix_val = op[1] ? rem : quo;
        else
            fix_val = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op       <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op    <= bus.funct3;
            cnt   <= '0;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            if (early)
                result_q <= early_val;
            if (bus.funct3[2]) begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
            end
        end else if (!bus.flush) begin
            if (state == CALC) begin
                acc <= op[2] ? div_next : mul_next;
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                result_q <= fix_val;
            end
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed scenarios plus a randomized
// run scored against a plain-arithmetic reference model.
module tb_mdu_sequencer;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus();

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: 64-bit arithmetic with the RISC-V corner-case rules.
    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [63:0] sa, sb, sq;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sq = sa / sb; return sq[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sq = sa % sb; return sq[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_done_cycle(input logic [2:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
        return W + 1;
    endfunction

    // Present a request for one edge; leaves the bench at #1 into cycle 0.
    task automatic drive_start(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.srca   = a;
        bus.srcb   = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom_range(0, 7));
        bus.srca   = $urandom;
        bus.srcb   = $urandom;
    endtask

    task automatic wait_done(output int done_cyc, output int busy_cnt, output logic [W-1:0] res);
        done_cyc = -1;
        busy_cnt = 0;
        res      = 'x;
        for (int c = 0; c < 100; c++) begin
            if (bus.done) begin
                done_cyc = c;
                res      = bus.result;
                return;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_cyc, output int busy_cnt, output logic [W-1:0] res);
        drive_start(f, a, b);
        wait_done(done_cyc, busy_cnt, res);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.srca   = '0;
        bus.srcb   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    endtask

    task automatic test_mul;
        int dc, bc; logic [W-1:0] r;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, dc, bc, r);
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", r); end
        checks++; if (dc != 33) begin errors++; $display("FAIL mul_done_cycle: got %0d want 33", dc); end
        checks++; if (bc != 33) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
        idle(2);
    endtask

    task automatic test_mulh;
        int dc, bc; logic [W-1:0] r;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, r);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu: got %h want fffffffe", r); end
        idle(1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, r);
        checks++; if (r !== 32'h0000_0000) begin errors++; $display("FAIL mulh: got %h want 00000000", r); end
        idle(1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu: got %h want ffffffff", r); end
        idle(1);
    endtask

    task automatic test_div;
        int dc, bc; logic [W-1:0] r;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, dc, bc, r);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h want fffffffd", r); end
        idle(1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, dc, bc, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %h want ffffffff", r); end
        idle(1);
        run_op(3'd5, 32'd100, 32'd7, dc, bc, r);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu: got %0d want 14", r); end
        idle(1);
        run_op(3'd7, 32'd100, 32'd7, dc, bc, r);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu: got %0d want 2", r); end
        idle(1);
    endtask

    task automatic test_early_out;
        logic [2:0]   f [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [W-1:0] a [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] e [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int dc, bc; logic [W-1:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], dc, bc, r);
            checks++; if (r !== e[i]) begin errors++; $display("FAIL early_result[%0d]: got %h want %h", i, r, e[i]); end
            checks++; if (dc != 0) begin errors++; $display("FAIL early_done_cycle[%0d]: got %0d want 0", i, dc); end
            checks++; if (bc != 0) begin errors++; $display("FAIL early_busy[%0d]: got %0d want 0", i, bc); end
            idle(1);
        end
    endtask

    task automatic test_ignored_start;
        int dc, bc; logic [W-1:0] r;
        drive_start(3'd0, 32'd12345, 32'd678);
        idle(5);
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.srca   = 32'd100;
        bus.srcb   = 32'd7;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        wait_done(dc, bc, r);
        checks++; if (r !== model(3'd0, 32'd12345, 32'd678)) begin errors++; $display("FAIL ignored_start_result: got %h want %h", r, model(3'd0, 32'd12345, 32'd678)); end
        checks++; if (dc + 6 != 33) begin errors++; $display("FAIL ignored_start_done_cycle: got %0d want 33", dc + 6); end
        idle(2);
    endtask

    task automatic test_flush;
        int dc, bc; logic [W-1:0] r, prev;
        prev = bus.result;
        drive_start(3'd0, 32'd3, 32'd5);
        idle(10);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== prev) begin errors++; $display("FAIL flush_result: got %h want %h", bus.result, prev); end
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, dc, bc, r);
        checks++; if (dc != 33) begin errors++; $display("FAIL flush_next_done_cycle: got %0d want 33", dc); end
        checks++; if (r !== model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)) begin errors++; $display("FAIL flush_next_result: got %h want %h", r, model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)); end
        idle(1);
    endtask

    task automatic test_reset_mid;
        checks++; if (bus.result === 32'd0) begin errors++; $display("FAIL reset_mid_precond: got %h want nonzero", bus.result); end
        drive_start(3'd4, 32'd1000, 32'd3);
        idle(10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_mid_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_mid_result: got %h want 0", bus.result); end
        idle(1);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_back_to_back;
        int dc, bc; logic [W-1:0] r;
        run_op(3'd5, 32'd100, 32'd7, dc, bc, r);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_first_result: got %0d want 14", r); end
        drive_start(3'd0, 32'd7, 32'hFFFF_FFFD);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got busy=%b want 1", bus.busy); end
        wait_done(dc, bc, r);
        checks++; if (dc + 1 != 34) begin errors++; $display("FAIL b2b_second_done: got %0d cycles want 34", dc + 1); end
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_second_result: got %h want ffffffeb", r); end
        idle(1);
    endtask

    task automatic test_random;
        int dc, bc, exp_dc; logic [W-1:0] r, a, b, e; logic [2:0] f; int sel;
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 20));
            exp_q.push_back(model(f, a, b));
            exp_dc = model_done_cycle(f, a, b);
            run_op(f, a, b, dc, bc, r);
            e = exp_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h want %h", i, f, a, b, r, e); end
            checks++; if (dc != exp_dc) begin errors++; $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", i, dc, exp_dc); end
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_early_out();
        test_ignored_start();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
